// File: rtl/tmds_word_aligner_if.sv
// Lane-side bus of the TMDS word aligner: IDDR bit pairs in, aligned words and lock status out.
// word_valid is a one-cycle strobe with no ready: the consumer must take word_out in that cycle (no backpressure).
interface tmds_word_aligner_if #(
    parameter int NUM_CH = 3
);
    logic [2*NUM_CH-1:0]  q_in;
    logic [10*NUM_CH-1:0] word_out;
    logic                 word_valid;
    logic [NUM_CH-1:0]    locked;
    logic [4*NUM_CH-1:0]  slip;
    logic                 all_locked;

    modport master (
        output q_in,
        input  word_out,
        input  word_valid,
        input  locked,
        input  slip,
        input  all_locked
    );

    modport slave (
        input  q_in,
        output word_out,
        output word_valid,
        output locked,
        output slip,
        output all_locked
    );
endinterface

// File: rtl/tmds_word_aligner.sv
// Per-lane TMDS word aligner: builds 10-bit words every 5 clk_shift cycles and hunts the bit-slip
// on control tokens, declaring lock after a run of consecutive tokens.
module tmds_word_aligner #(
    parameter int NUM_CH       = 3,
    parameter int LOCK_TOKENS  = 16,
    parameter int SEARCH_WORDS = 4096,
    parameter int LOSS_WORDS   = 65536
) (
    input  logic              clk_shift,
    input  logic              rst_n,
    tmds_word_aligner_if.slave bus,
    output logic [NUM_CH-1:0] state_dbg_o
);
    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int RUN_W    = $clog2(LOCK_TOKENS + 1);
    localparam int IDLE_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
    localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

    localparam logic [RUN_W-1:0]  RUN_SAT    = RUN_W'(LOCK_TOKENS);
    localparam logic [IDLE_W-1:0] IDLE_SAT   = IDLE_W'(IDLE_MAX);
    localparam logic [IDLE_W-1:0] SEARCH_END = IDLE_W'(SEARCH_WORDS);
    localparam logic [IDLE_W-1:0] LOSS_END   = IDLE_W'(LOSS_WORDS);

    logic [2:0]        phase_q, phase_d;
    logic              word_valid_q;
    logic              all_locked_q;
    logic [NUM_CH-1:0] locked_w;

    assign phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;

    // All lanes share one word phase, so one strobe serves every lane.
    always_ff @(posedge clk_shift) begin
        if (!rst_n) begin
            phase_q      <= 3'd0;
            word_valid_q <= 1'b0;
            all_locked_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            word_valid_q <= (phase_q == 3'd4);
            all_locked_q <= &locked_w;
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.all_locked = all_locked_q;
    assign bus.locked     = locked_w;
    assign state_dbg_o    = locked_w;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [19:0]       sr_q, sr_d, sr_shift;
        logic [9:0]        word_q, word_d;
        logic [0:0]        st_q, st_d;
        logic [3:0]        slip_q, slip_d;
        logic [RUN_W-1:0]  run_q, run_d, run_inc;
        logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
        logic              tok;

        // Older sample sits at the lower index, so TMDS bit 0 lands lowest in the word.
        assign sr_d     = {bus.q_in[2*k+1], bus.q_in[2*k], sr_q[19:2]};
        assign sr_shift = sr_d >> slip_q;
        assign word_d   = (phase_q == 3'd4) ? sr_shift[9:0] : word_q;

        assign tok = (word_q == 10'h354) || (word_q == 10'h0AB) ||
                     (word_q == 10'h154) || (word_q == 10'h2AB);

        assign run_inc  = (run_q == RUN_SAT) ? run_q : run_q + RUN_W'(1);
        assign idle_inc = (idle_q == IDLE_SAT) ? idle_q : idle_q + IDLE_W'(1);

        always_comb begin
            st_d   = st_q;
            slip_d = slip_q;
            run_d  = run_q;
            idle_d = idle_q;
            if (word_valid_q) begin
                case (st_q)
                    ST_SEARCH: begin
                        if (tok) begin
                            run_d  = run_inc;
                            idle_d = '0;
                            if (run_inc >= RUN_SAT) begin
                                st_d  = ST_LOCKED;
                                run_d = '0;
                            end
                        end else begin
                            run_d  = '0;
                            idle_d = idle_inc;
                            if (idle_inc >= SEARCH_END) begin
                                slip_d = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                                idle_d = '0;
                            end
                        end
                    end
                    default: begin
                        if (tok) begin
                            idle_d = '0;
                        end else begin
                            idle_d = idle_inc;
                            if (idle_inc >= LOSS_END) begin
                                st_d   = ST_SEARCH;
                                run_d  = '0;
                                idle_d = '0;
                            end
                        end
                    end
                endcase
            end
        end

        always_ff @(posedge clk_shift) begin
            if (!rst_n) begin
                sr_q   <= '0;
                word_q <= '0;
                st_q   <= ST_SEARCH;
                slip_q <= 4'd0;
                run_q  <= '0;
                idle_q <= '0;
            end else begin
                sr_q   <= sr_d;
                word_q <= word_d;
                st_q   <= st_d;
                slip_q <= slip_d;
                run_q  <= run_d;
                idle_q <= idle_d;
            end
        end

        assign bus.word_out[10*k +: 10] = word_q;
        assign bus.slip[4*k +: 4]       = slip_q;
        assign locked_w[k]              = (st_q == ST_LOCKED);
    end
endmodule
